// File: rtl/wt_cache_pkg.sv
// Shared constants and table entry type for the write-through cache memory arbiter.
package wt_cache_pkg;

  localparam logic WT_SRC_ICACHE = 1'b0;
  localparam logic WT_SRC_DCACHE = 1'b1;

  typedef struct packed {
    logic valid;
    logic src;
  } wt_arb_entry_t;

endpackage

// File: rtl/wt_mem_arbiter_if.sv
// Bundle of the I$/D$ request, adapter and return signals around wt_mem_arbiter.
interface wt_mem_arbiter_if #(
  parameter int TidWidth     = 2,
  parameter int PayloadWidth = 128
);
  logic                    icache_req;
  logic [TidWidth-1:0]     icache_tid;
  logic [PayloadWidth-1:0] icache_payload;
  logic                    icache_ack;
  logic                    dcache_req;
  logic [TidWidth-1:0]     dcache_tid;
  logic [PayloadWidth-1:0] dcache_payload;
  logic                    dcache_ack;
  logic                    mem_req;
  logic [TidWidth-1:0]     mem_tid;
  logic [PayloadWidth-1:0] mem_payload;
  logic                    mem_src;
  logic                    mem_ack;
  logic                    mem_rtrn_vld;
  logic [TidWidth-1:0]     mem_rtrn_tid;
  logic                    icache_rtrn_vld;
  logic                    dcache_rtrn_vld;
  logic                    rtrn_err;
  logic                    idle;

  // Caches plus adapter side: drives requests, acks and returns.
  modport master (
    output icache_req, icache_tid, icache_payload, dcache_req, dcache_tid, dcache_payload,
    output mem_ack, mem_rtrn_vld, mem_rtrn_tid,
    input  icache_ack, dcache_ack, mem_req, mem_tid, mem_payload, mem_src,
    input  icache_rtrn_vld, dcache_rtrn_vld, rtrn_err, idle
  );

  // Arbiter side.
  modport slave (
    input  icache_req, icache_tid, icache_payload, dcache_req, dcache_tid, dcache_payload,
    input  mem_ack, mem_rtrn_vld, mem_rtrn_tid,
    output icache_ack, dcache_ack, mem_req, mem_tid, mem_payload, mem_src,
    output icache_rtrn_vld, dcache_rtrn_vld, rtrn_err, idle
  );
endinterface

// File: rtl/wt_mem_arb_rr.sv
// Two-input round-robin picker; holds its grant while the adapter back-pressures.
module wt_mem_arb_rr
  import wt_cache_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] elig_i,
  input  logic       last_src_i,
  input  logic       ack_i,
  output logic       grant_vld_o,
  output logic       grant_src_o,
  output logic       locked_o
);

  logic locked_q, locked_d;
  logic lock_src_q, lock_src_d;

  always_comb begin
    grant_vld_o = 1'b0;
    grant_src_o = WT_SRC_ICACHE;
    if (!rst_i) begin
      // A locked requester keeps the grant without re-checking eligibility.
      if (locked_q) begin
        grant_vld_o = 1'b1;
        grant_src_o = lock_src_q;
      end else if (&elig_i) begin
        grant_vld_o = 1'b1;
        grant_src_o = ~last_src_i;
      end else if (elig_i[0]) begin
        grant_vld_o = 1'b1;
        grant_src_o = WT_SRC_ICACHE;
      end else if (elig_i[1]) begin
        grant_vld_o = 1'b1;
        grant_src_o = WT_SRC_DCACHE;
      end
    end
    locked_d   = grant_vld_o & ~ack_i;
    lock_src_d = grant_src_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q   <= 1'b0;
      lock_src_q <= WT_SRC_ICACHE;
    end else begin
      locked_q   <= locked_d;
      lock_src_q <= lock_src_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/wt_mem_arbiter.sv
// Arbitrates I$/D$ memory requests onto one adapter port and routes returns by
// transaction ID through an outstanding table.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int TidWidth     = 2,
  parameter int PayloadWidth = 128,
  parameter int MaxOutIcache = 1,
  parameter int MaxOutDcache = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    icache_req_i,
  input  logic [TidWidth-1:0]     icache_tid_i,
  input  logic [PayloadWidth-1:0] icache_payload_i,
  output logic                    icache_ack_o,
  input  logic                    dcache_req_i,
  input  logic [TidWidth-1:0]     dcache_tid_i,
  input  logic [PayloadWidth-1:0] dcache_payload_i,
  output logic                    dcache_ack_o,
  output logic                    mem_req_o,
  output logic [TidWidth-1:0]     mem_tid_o,
  output logic [PayloadWidth-1:0] mem_payload_o,
  output logic                    mem_src_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_rtrn_vld_i,
  input  logic [TidWidth-1:0]     mem_rtrn_tid_i,
  output logic                    icache_rtrn_vld_o,
  output logic                    dcache_rtrn_vld_o,
  output logic                    rtrn_err_o,
  output logic                    idle_o
);

  localparam int NumTx = 2 ** TidWidth;
  localparam int CntW  = $clog2(NumTx + 1);
  localparam logic [CntW-1:0] MaxI = CntW'(MaxOutIcache);
  localparam logic [CntW-1:0] MaxD = CntW'(MaxOutDcache);

  wt_arb_entry_t   table_q [NumTx];
  wt_arb_entry_t   table_d [NumTx];
  logic [CntW-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
  logic            last_src_q, last_src_d;

  logic [1:0]      elig;
  logic            grant_vld, grant_src, locked, accept, rtrn_hit;
  wt_arb_entry_t   rtrn_entry;

  assign elig[0] = icache_req_i & ~table_q[icache_tid_i].valid & (icnt_q < MaxI);
  assign elig[1] = dcache_req_i & ~table_q[dcache_tid_i].valid & (dcnt_q < MaxD);

  wt_mem_arb_rr u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .elig_i      (elig),
    .last_src_i  (last_src_q),
    .ack_i       (mem_ack_i),
    .grant_vld_o (grant_vld),
    .grant_src_o (grant_src),
    .locked_o    (locked)
  );

  assign accept        = grant_vld & mem_ack_i;
  assign mem_req_o     = grant_vld;
  assign mem_src_o     = grant_vld & grant_src;
  assign mem_tid_o     = !grant_vld ? '0 :
                         (grant_src == WT_SRC_DCACHE) ? dcache_tid_i : icache_tid_i;
  assign mem_payload_o = !grant_vld ? '0 :
                         (grant_src == WT_SRC_DCACHE) ? dcache_payload_i : icache_payload_i;
  assign icache_ack_o  = accept & (grant_src == WT_SRC_ICACHE);
  assign dcache_ack_o  = accept & (grant_src == WT_SRC_DCACHE);

  assign rtrn_entry        = table_q[mem_rtrn_tid_i];
  assign rtrn_hit          = mem_rtrn_vld_i & ~rst_i & rtrn_entry.valid;
  assign icache_rtrn_vld_o = rtrn_hit & (rtrn_entry.src == WT_SRC_ICACHE);
  assign dcache_rtrn_vld_o = rtrn_hit & (rtrn_entry.src == WT_SRC_DCACHE);
  assign rtrn_err_o        = mem_rtrn_vld_i & ~rst_i & ~rtrn_entry.valid;
  assign idle_o            = ~locked & (icnt_q == '0) & (dcnt_q == '0);

  always_comb begin
    table_d = table_q;
    // Return clears before accept sets, so a same-tid reuse keeps the new entry.
    if (rtrn_hit) table_d[mem_rtrn_tid_i].valid = 1'b0;
    if (accept)   table_d[mem_tid_o] = '{valid: 1'b1, src: grant_src};
    icnt_d = icnt_q + CntW'(icache_ack_o) - CntW'(icache_rtrn_vld_o);
    dcnt_d = dcnt_q + CntW'(dcache_ack_o) - CntW'(dcache_rtrn_vld_o);
    last_src_d = accept ? grant_src : last_src_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumTx; i++) table_q[i] <= '0;
      icnt_q     <= '0;
      dcnt_q     <= '0;
      last_src_q <= WT_SRC_DCACHE;
    end else begin
      table_q    <= table_d;
      icnt_q     <= icnt_d;
      dcnt_q     <= dcnt_d;
      last_src_q <= last_src_d;
    end
  end

  a_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    locked |-> $stable(mem_payload_o));
  a_icnt_max: assert property (@(posedge clk_i) disable iff (rst_i) icnt_q <= MaxI);
  a_dcnt_max: assert property (@(posedge clk_i) disable iff (rst_i) dcnt_q <= MaxD);

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed table-driven bench for wt_mem_arbiter: one vector per clock cycle.
module tb_wt_mem_arbiter;
  import wt_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wt_mem_arbiter_if #(.TidWidth(2), .PayloadWidth(128)) bus ();

  wt_mem_arbiter #(
    .TidWidth(2), .PayloadWidth(128), .MaxOutIcache(1), .MaxOutDcache(4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .icache_req_i      (bus.icache_req),
    .icache_tid_i      (bus.icache_tid),
    .icache_payload_i  (bus.icache_payload),
    .icache_ack_o      (bus.icache_ack),
    .dcache_req_i      (bus.dcache_req),
    .dcache_tid_i      (bus.dcache_tid),
    .dcache_payload_i  (bus.dcache_payload),
    .dcache_ack_o      (bus.dcache_ack),
    .mem_req_o         (bus.mem_req),
    .mem_tid_o         (bus.mem_tid),
    .mem_payload_o     (bus.mem_payload),
    .mem_src_o         (bus.mem_src),
    .mem_ack_i         (bus.mem_ack),
    .mem_rtrn_vld_i    (bus.mem_rtrn_vld),
    .mem_rtrn_tid_i    (bus.mem_rtrn_tid),
    .icache_rtrn_vld_o (bus.icache_rtrn_vld),
    .dcache_rtrn_vld_o (bus.dcache_rtrn_vld),
    .rtrn_err_o        (bus.rtrn_err),
    .idle_o            (bus.idle)
  );

  typedef struct {
    string    name;
    bit       ir;  bit [1:0] it;
    bit       dr;  bit [1:0] dt;
    bit       ack;
    bit       rv;  bit [1:0] rt;
    bit       mreq; bit msrc; bit [1:0] mtid;
    bit       iack; bit dack; bit irv; bit drv; bit err; bit idle;
  } vec_t;

  vec_t vecs[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic logic [127:0] pay(input logic src, input logic [1:0] tid);
    return {{30{(src == WT_SRC_DCACHE) ? 4'hD : 4'hA}}, 6'b0, tid};
  endfunction

  function automatic vec_t mk(input string n,
                              input bit ir, input bit [1:0] it, input bit dr, input bit [1:0] dt,
                              input bit ack, input bit rv, input bit [1:0] rt,
                              input bit mreq, input bit msrc, input bit [1:0] mtid,
                              input bit iack, input bit dack, input bit irv, input bit drv,
                              input bit err, input bit idle);
    vec_t v;
    v.name = n; v.ir = ir; v.it = it; v.dr = dr; v.dt = dt; v.ack = ack; v.rv = rv; v.rt = rt;
    v.mreq = mreq; v.msrc = msrc; v.mtid = mtid; v.iack = iack; v.dack = dack;
    v.irv = irv; v.drv = drv; v.err = err; v.idle = idle;
    return v;
  endfunction

  task automatic check(input vec_t v);
    logic [10:0] got, exp;
    logic        pay_ok;
    pay_ok = v.mreq ? (bus.mem_payload === pay(v.msrc, v.mtid)) : 1'b1;
    got = {bus.mem_req, v.mreq ? bus.mem_src : 1'b0, v.mreq ? bus.mem_tid : 2'b00,
           bus.icache_ack, bus.dcache_ack, bus.icache_rtrn_vld, bus.dcache_rtrn_vld,
           bus.rtrn_err, bus.idle, pay_ok};
    exp = {v.mreq, v.mreq & v.msrc, v.mreq ? v.mtid : 2'b00,
           v.iack, v.dack, v.irv, v.drv, v.err, v.idle, 1'b1};
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: req,src,tid,iack,dack,irv,drv,err,idle,pay got %b required %b",
               v.name, got, exp);
    end else begin
      $display("[TB] %s: %b ok", v.name, got);
    end
  endtask

  task automatic apply(input bit r, input vec_t v);
    @(posedge clk);
    #1;
    rst                = r;
    bus.icache_req     = v.ir;
    bus.icache_tid     = v.it;
    bus.icache_payload = pay(WT_SRC_ICACHE, v.it);
    bus.dcache_req     = v.dr;
    bus.dcache_tid     = v.dt;
    bus.dcache_payload = pay(WT_SRC_DCACHE, v.dt);
    bus.mem_ack        = v.ack;
    bus.mem_rtrn_vld   = v.rv;
    bus.mem_rtrn_tid   = v.rt;
    @(negedge clk);
    check(v);
  endtask

  initial begin
    bus.icache_req = 0; bus.icache_tid = 0; bus.icache_payload = '0;
    bus.dcache_req = 0; bus.dcache_tid = 0; bus.dcache_payload = '0;
    bus.mem_ack = 0; bus.mem_rtrn_vld = 0; bus.mem_rtrn_tid = 0;

    //            name          ir it dr dt ack rv rt  mreq src tid iack dack irv drv err idle
    vecs.push_back(mk("tie_i",      1,0, 1,1, 1,  0,0,  1,0,0,  1,0,0,0,0,1));
    vecs.push_back(mk("d_ret0",     0,0, 1,1, 1,  1,0,  1,1,1,  0,1,1,0,0,0));
    vecs.push_back(mk("ret1",       0,0, 0,0, 0,  1,1,  0,0,0,  0,0,0,1,0,0));
    vecs.push_back(mk("bp0",        1,0, 0,0, 0,  0,0,  1,0,0,  0,0,0,0,0,1));
    vecs.push_back(mk("bp1",        1,0, 1,1, 0,  0,0,  1,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk("bp2",        1,0, 1,1, 0,  0,0,  1,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk("bp_ack",     1,0, 1,1, 1,  0,0,  1,0,0,  1,0,0,0,0,0));
    vecs.push_back(mk("d_after_bp", 1,3, 1,1, 1,  0,0,  1,1,1,  0,1,0,0,0,0));
    vecs.push_back(mk("lim_d2",     1,3, 1,2, 1,  0,0,  1,1,2,  0,1,0,0,0,0));
    vecs.push_back(mk("coll",       1,3, 1,2, 1,  0,0,  0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk("coll_ret2",  1,3, 1,2, 1,  1,2,  0,0,0,  0,0,0,1,0,0));
    vecs.push_back(mk("coll_grant", 1,3, 1,2, 1,  0,0,  1,1,2,  0,1,0,0,0,0));
    vecs.push_back(mk("lim_ret0",   1,3, 0,0, 1,  1,0,  0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk("lim_grant",  1,3, 0,0, 1,  0,0,  1,0,3,  1,0,0,0,0,0));
    vecs.push_back(mk("ret3_i",     0,0, 0,0, 0,  1,3,  0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk("ret1_d",     0,0, 0,0, 0,  1,1,  0,0,0,  0,0,0,1,0,0));
    vecs.push_back(mk("i_tid1",     1,1, 0,0, 1,  0,0,  1,0,1,  1,0,0,0,0,0));
    vecs.push_back(mk("acc_d_ret_i",0,0, 1,0, 1,  1,1,  1,1,0,  0,1,1,0,0,0));
    vecs.push_back(mk("i_reuse1",   1,1, 0,0, 1,  0,0,  1,0,1,  1,0,0,0,0,0));
    vecs.push_back(mk("d_plus_minus",0,0,1,3, 1,  1,2,  1,1,3,  0,1,0,1,0,0));
    vecs.push_back(mk("drain0",     0,0, 0,0, 0,  1,0,  0,0,0,  0,0,0,1,0,0));
    vecs.push_back(mk("drain1",     0,0, 0,0, 0,  1,1,  0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk("drain3",     0,0, 0,0, 0,  1,3,  0,0,0,  0,0,0,1,0,0));
    vecs.push_back(mk("idle_chk",   0,0, 0,0, 0,  0,0,  0,0,0,  0,0,0,0,0,1));
    vecs.push_back(mk("spur3",      0,0, 0,0, 0,  1,3,  0,0,0,  0,0,0,0,1,1));
    vecs.push_back(mk("after_spur", 0,0, 0,0, 0,  0,0,  0,0,0,  0,0,0,0,0,1));
    vecs.push_back(mk("tie2_i",     1,2, 1,3, 1,  0,0,  1,0,2,  1,0,0,0,0,1));
    vecs.push_back(mk("i_max_ret2", 1,0, 0,0, 0,  1,2,  0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk("tie3_d",     1,0, 1,3, 1,  0,0,  1,1,3,  0,1,0,0,0,1));
    vecs.push_back(mk("tie4_i",     1,0, 1,0, 1,  0,0,  1,0,0,  1,0,0,0,0,0));
    vecs.push_back(mk("fin_ret3",   0,0, 0,0, 0,  1,3,  0,0,0,  0,0,0,1,0,0));
    vecs.push_back(mk("fin_ret0",   0,0, 0,0, 0,  1,0,  0,0,0,  0,0,1,0,0,0));
    vecs.push_back(mk("fin_idle",   0,0, 0,0, 0,  0,0,  0,0,0,  0,0,0,0,0,1));

    // Reset: outputs forced low even with requests and ack presented.
    apply(1'b1, mk("rst_a",   0,0, 0,0, 0, 0,0, 0,0,0, 0,0,0,0,0,1));
    n_run++;
    if ({bus.mem_tid, bus.mem_payload} !== '0) begin
      n_fail++;
      $display("FAIL rst_tid_pay: got tid %0d payload %h required 0", bus.mem_tid, bus.mem_payload);
    end
    apply(1'b1, mk("rst_req", 1,0, 1,1, 1, 0,0, 0,0,0, 0,0,0,0,0,1));
    apply(1'b0, mk("post_rst",0,0, 0,0, 0, 0,0, 0,0,0, 0,0,0,0,0,1));

    foreach (vecs[i]) apply(1'b0, vecs[i]);

    // Reset mid-operation: stale return reports an error, last_src back to D$.
    apply(1'b0, mk("pre_rst_acc", 1,1, 0,0, 1, 0,0, 1,0,1, 1,0,0,0,0,1));
    apply(1'b1, mk("mid_rst",     0,0, 0,0, 0, 0,0, 0,0,0, 0,0,0,0,0,0));
    apply(1'b0, mk("stale_ret",   0,0, 0,0, 0, 1,1, 0,0,0, 0,0,0,0,1,1));
    apply(1'b0, mk("rst_tie",     1,2, 1,3, 1, 0,0, 1,0,2, 1,0,0,0,0,1));

    @(posedge clk);
    #1;
    bus.icache_req = 0; bus.dcache_req = 0; bus.mem_ack = 0; bus.mem_rtrn_vld = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
